// File: rtl/integral_image_gen_pkg.sv
// Shared face-detect definitions: frame geometry defaults, integral widths,
// coordinate types and the pipeline state encoding.
package integral_image_gen_pkg;

    localparam int DEF_IMG_WIDTH  = 320;
    localparam int DEF_IMG_HEIGHT = 240;
    localparam int DEF_II_W       = 25;
    localparam int DEF_II_SQ_W    = DEF_II_W + 8;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    typedef logic [clog2(DEF_IMG_WIDTH)-1:0]  col_t;
    typedef logic [clog2(DEF_IMG_HEIGHT)-1:0] row_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/ii_line_buffer.sv
// One-row store of the previous row's integral values: simple dual-port RAM,
// registered read with one cycle of latency, read-before-write on the same edge.
module ii_line_buffer
    import integral_image_gen_pkg::*;
#(
    parameter int DEPTH  = DEF_IMG_WIDTH,
    parameter int DATA_W = DEF_II_W,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rdEn,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [DATA_W-1:0] o_rdData,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Contents are never reset: row 0 of every frame ignores what is read back.
    always_ff @(posedge i_clk) begin
        if (i_rdEn) begin
            o_rdData <= r_mem[i_rdAddr];
        end
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

endmodule

// File: rtl/integral_image_gen.sv
// Streaming integral-image generator, two-stage pipeline over a raster pixel stream.
// Optional squared integral output (oII_sq) is enabled by defining II_SQUARED_EN.
module integral_image_gen
    import integral_image_gen_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int II_W       = DEF_II_W
) (
    input  logic                          iClk,
    input  logic                          iReset,
    input  logic                          iFrame_start,
    input  logic                          iInput_ready,
    input  logic [7:0]                    iY,
    output logic                          oOutput_ready,
    output logic [II_W-1:0]               oII,
`ifdef II_SQUARED_EN
    output logic [II_W+7:0]               oII_sq,
`endif
    output logic [clog2(IMG_WIDTH)-1:0]   oCol,
    output logic [clog2(IMG_HEIGHT)-1:0]  oRow,
    output logic                          oFrame_done
);

    localparam int COL_W = clog2(IMG_WIDTH);
    localparam int ROW_W = clog2(IMG_HEIGHT);
    localparam int RS_W  = clog2(IMG_WIDTH * 255 + 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

    state_e           r_state;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [RS_W-1:0]  r_rowSum;
    logic             r_valid1;
    logic [COL_W-1:0] r_colD;
    logic [ROW_W-1:0] r_rowD;
    logic             r_firstRow;
    logic             r_lastD;

    logic             w_start;
    logic             w_accept;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_colLast;
    logic             w_rowLast;
    logic [II_W-1:0]  w_lbRdata;
    logic [II_W-1:0]  w_iiSum;

    // A frame-start beat always restarts at (0,0), even in the middle of a frame.
    assign w_start   = iInput_ready & iFrame_start;
    assign w_accept  = iInput_ready & (iFrame_start | (r_state == ACTIVE));
    assign w_col     = w_start ? '0 : r_col;
    assign w_row     = w_start ? '0 : r_row;
    assign w_colLast = (w_col == LAST_COL);
    assign w_rowLast = (w_row == LAST_ROW);

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_state    <= IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_rowSum   <= '0;
            r_valid1   <= 1'b0;
            r_colD     <= '0;
            r_rowD     <= '0;
            r_firstRow <= 1'b0;
            r_lastD    <= 1'b0;
        end else begin
            r_valid1 <= w_accept;
            if (w_accept) begin
                r_rowSum   <= (w_col == '0 ? '0 : r_rowSum) + RS_W'(iY);
                r_colD     <= w_col;
                r_rowD     <= w_row;
                r_firstRow <= (w_row == '0);
                r_lastD    <= w_colLast & w_rowLast;
                if (w_colLast & w_rowLast) begin
                    r_state <= IDLE;
                    r_col   <= '0;
                    r_row   <= '0;
                end else if (w_colLast) begin
                    r_state <= ACTIVE;
                    r_col   <= '0;
                    r_row   <= w_row + ROW_W'(1);
                end else begin
                    r_state <= ACTIVE;
                    r_col   <= w_col + COL_W'(1);
                    r_row   <= w_row;
                end
            end
        end
    end

    assign w_iiSum = II_W'(r_rowSum) + (r_firstRow ? '0 : w_lbRdata);

    always_ff @(posedge iClk) begin
        if (iReset) begin
            oOutput_ready <= 1'b0;
            oFrame_done   <= 1'b0;
            oII           <= '0;
            oCol          <= '0;
            oRow          <= '0;
        end else begin
            oOutput_ready <= r_valid1;
            oFrame_done   <= r_valid1 & r_lastD;
            if (r_valid1) begin
                oII  <= w_iiSum;
                oCol <= r_colD;
                oRow <= r_rowD;
            end
        end
    end

    // Reads for column c overlap the write of column c-1, so the addresses never collide.
    ii_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (II_W),
        .ADDR_W (COL_W)
    ) u_lineBuffer (
        .i_clk    (iClk),
        .i_rdEn   (w_accept),
        .i_rdAddr (w_col),
        .o_rdData (w_lbRdata),
        .i_wrEn   (r_valid1),
        .i_wrAddr (r_colD),
        .i_wrData (w_iiSum)
    );

`ifdef II_SQUARED_EN
    localparam int II_SQ_W = II_W + 8;
    localparam int RSQ_W   = clog2(IMG_WIDTH * 65025 + 1);

    logic [RSQ_W-1:0]   r_rowSqSum;
    logic [15:0]        w_ySq;
    logic [II_SQ_W-1:0] w_lbSqRdata;
    logic [II_SQ_W-1:0] w_iiSqSum;

    assign w_ySq = 16'(iY) * 16'(iY);

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_rowSqSum <= '0;
        end else if (w_accept) begin
            r_rowSqSum <= (w_col == '0 ? '0 : r_rowSqSum) + RSQ_W'(w_ySq);
        end
    end

    assign w_iiSqSum = II_SQ_W'(r_rowSqSum) + (r_firstRow ? '0 : w_lbSqRdata);

    always_ff @(posedge iClk) begin
        if (iReset) begin
            oII_sq <= '0;
        end else if (r_valid1) begin
            oII_sq <= w_iiSqSum;
        end
    end

    ii_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (II_SQ_W),
        .ADDR_W (COL_W)
    ) u_sqLineBuffer (
        .i_clk    (iClk),
        .i_rdEn   (w_accept),
        .i_rdAddr (w_col),
        .o_rdData (w_lbSqRdata),
        .i_wrEn   (r_valid1),
        .i_wrAddr (r_colD),
        .i_wrData (w_iiSqSum)
    );
`endif

endmodule

// File: tb/tb_integral_image_gen.sv
// Directed bench: a 4x3 instance driven from a cycle table, plus a full-size
// 320x240 instance swept with a saturated frame in parallel.
module tb_integral_image_gen;
    import integral_image_gen_pkg::*;

    typedef struct {
        logic        rst;
        logic        fs;
        logic        rdy;
        logic [7:0]  y;
        logic        expRdy;
        logic        expDone;
        logic [24:0] expII;
        logic [1:0]  expCol;
        logic [1:0]  expRow;
        logic        chkSq;
        logic [32:0] expIISq;
    } vec_t;

    logic clock;
    int   assertCount = 0;
    int   failCount   = 0;
    vec_t vecs[$];

    logic        smallReset, smallFrameStart, smallReady;
    logic [7:0]  smallY;
    logic        smallOutReady, smallDone;
    logic [24:0] smallII;
    logic [1:0]  smallCol, smallRow;

    logic        fullReset, fullFrameStart, fullReady;
    logic [7:0]  fullY;
    logic        fullOutReady, fullDone;
    logic [24:0] fullII;
    col_t        fullCol;
    row_t        fullRow;

`ifdef II_SQUARED_EN
    logic [32:0] smallIISq;
    logic [32:0] fullIISq;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    integral_image_gen #(
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (3),
        .II_W       (25)
    ) dutSmall (
        .iClk          (clock),
        .iReset        (smallReset),
        .iFrame_start  (smallFrameStart),
        .iInput_ready  (smallReady),
        .iY            (smallY),
        .oOutput_ready (smallOutReady),
        .oII           (smallII),
`ifdef II_SQUARED_EN
        .oII_sq        (smallIISq),
`endif
        .oCol          (smallCol),
        .oRow          (smallRow),
        .oFrame_done   (smallDone)
    );

    integral_image_gen dutFull (
        .iClk          (clock),
        .iReset        (fullReset),
        .iFrame_start  (fullFrameStart),
        .iInput_ready  (fullReady),
        .iY            (fullY),
        .oOutput_ready (fullOutReady),
        .oII           (fullII),
`ifdef II_SQUARED_EN
        .oII_sq        (fullIISq),
`endif
        .oCol          (fullCol),
        .oRow          (fullRow),
        .oFrame_done   (fullDone)
    );

    task automatic checkVal(input string name, input int cycle,
                            input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s (cycle %0d): got %0d, expected %0d", name, cycle, actual, expected);
        end
    endtask

    function automatic void addCycle(input logic r, input logic f, input logic v, input logic [7:0] y);
        vec_t e;
        e = '{default: '0};
        e.rst = r;
        e.fs  = f;
        e.rdy = v;
        e.y   = y;
        vecs.push_back(e);
    endfunction

    function automatic void expectAt(input int k, input int ii, input int col, input int row, input bit done);
        vecs[k].expRdy  = 1'b1;
        vecs[k].expII   = 25'(ii);
        vecs[k].expCol  = 2'(col);
        vecs[k].expRow  = 2'(row);
        vecs[k].expDone = done;
    endfunction

    task automatic applyStimulus(input vec_t v);
        smallReset      = v.rst;
        smallFrameStart = v.fs;
        smallReady      = v.rdy;
        smallY          = v.y;
    endtask

    task automatic checkOutput(input vec_t v, input int k);
        checkVal("oOutput_ready", k, 64'(smallOutReady), 64'(v.expRdy));
        checkVal("oFrame_done",   k, 64'(smallDone),     64'(v.expDone));
        checkVal("oII",           k, 64'(smallII),       64'(v.expII));
        checkVal("oCol",          k, 64'(smallCol),      64'(v.expCol));
        checkVal("oRow",          k, 64'(smallRow),      64'(v.expRow));
`ifdef II_SQUARED_EN
        if (v.chkSq) begin
            checkVal("oII_sq", k, 64'(smallIISq), 64'(v.expIISq));
        end
`endif
    endtask

    task automatic runSmallTests();
        int onesExp[12] = '{1, 2, 3, 4, 2, 4, 6, 8, 3, 6, 9, 12};
        int rampExp[12] = '{0, 1, 3, 6, 4, 10, 18, 28, 12, 27, 45, 66};
        int twosExp[12] = '{2, 4, 6, 8, 4, 8, 12, 16, 6, 12, 18, 24};
        int sqExp[12]   = '{4, 8, 12, 16, 8, 16, 24, 32, 12, 24, 36, 48};
        int base;
        logic [24:0] holdII;
        logic [1:0]  holdCol;
        logic [1:0]  holdRow;

        // All-ones frame
        base = vecs.size();
        for (int i = 0; i < 12; i++) addCycle(1'b0, i == 0, 1'b1, 8'd1);
        repeat (2) addCycle(1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 12; i++) expectAt(base + 2 + i, onesExp[i], i % 4, i / 4, i == 11);

        // While idle: lone frame-start and un-started pixels are ignored
        addCycle(1'b0, 1'b1, 1'b0, 8'd77);
        addCycle(1'b0, 1'b0, 1'b1, 8'd50);
        addCycle(1'b0, 1'b0, 1'b1, 8'd60);
        repeat (2) addCycle(1'b0, 1'b0, 1'b0, 8'd0);

        // Gapped ramp frame, p(x,y) = x + 4y
        base = vecs.size();
        for (int i = 0; i < 12; i++) begin
            addCycle(1'b0, i == 0, 1'b1, 8'(i));
            addCycle(1'b0, 1'b0, 1'b0, 8'hAA);
        end
        repeat (2) addCycle(1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 12; i++) expectAt(base + 2 + 2 * i, rampExp[i], i % 4, i / 4, i == 11);

        // Frame restarted on its sixth pixel
        base = vecs.size();
        for (int i = 0; i < 17; i++) addCycle(1'b0, (i == 0) || (i == 5), 1'b1, 8'd1);
        repeat (2) addCycle(1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) expectAt(base + 2 + i, onesExp[i], i % 4, i / 4, 1'b0);
        for (int j = 0; j < 12; j++) expectAt(base + 7 + j, onesExp[j], j % 4, j / 4, j == 11);

        // Reset after five pixels, stray pixels, then a clean frame
        base = vecs.size();
        for (int i = 0; i < 5; i++) addCycle(1'b0, i == 0, 1'b1, 8'd1);
        addCycle(1'b1, 1'b0, 1'b0, 8'd0);
        repeat (3) addCycle(1'b0, 1'b0, 1'b1, 8'd1);
        for (int i = 0; i < 12; i++) addCycle(1'b0, i == 0, 1'b1, 8'd1);
        repeat (2) addCycle(1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) expectAt(base + 2 + i, onesExp[i], i % 4, i / 4, 1'b0);
        for (int j = 0; j < 12; j++) expectAt(base + 11 + j, onesExp[j], j % 4, j / 4, j == 11);

        // Constant-two frame, also exercising the squared output
        base = vecs.size();
        for (int i = 0; i < 12; i++) addCycle(1'b0, i == 0, 1'b1, 8'd2);
        repeat (2) addCycle(1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 12; i++) begin
            expectAt(base + 2 + i, twosExp[i], i % 4, i / 4, i == 11);
            vecs[base + 2 + i].chkSq   = 1'b1;
            vecs[base + 2 + i].expIISq = 33'(sqExp[i]);
        end

        // Idle cycles hold the last valid result; a reset clears it
        holdII  = '0;
        holdCol = '0;
        holdRow = '0;
        for (int k = 0; k < vecs.size(); k++) begin
            if (k > 0 && vecs[k - 1].rst) begin
                holdII  = '0;
                holdCol = '0;
                holdRow = '0;
            end
            if (vecs[k].expRdy) begin
                holdII  = vecs[k].expII;
                holdCol = vecs[k].expCol;
                holdRow = vecs[k].expRow;
            end else begin
                vecs[k].expII  = holdII;
                vecs[k].expCol = holdCol;
                vecs[k].expRow = holdRow;
            end
        end

        smallReset      = 1'b1;
        smallFrameStart = 1'b0;
        smallReady      = 1'b0;
        smallY          = 8'd0;
        repeat (2) @(posedge clock);
        #1;
        smallReset = 1'b0;
        checkVal("reset oOutput_ready", -1, 64'(smallOutReady), 64'd0);
        checkVal("reset oFrame_done",   -1, 64'(smallDone),     64'd0);
        checkVal("reset oII",           -1, 64'(smallII),       64'd0);
        checkVal("reset oCol",          -1, 64'(smallCol),      64'd0);
        checkVal("reset oRow",          -1, 64'(smallRow),      64'd0);

        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k]);
            checkOutput(vecs[k], k);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic runFullFrame();
        int          outCount  = 0;
        int          doneCount = 0;
        int          sweepErr  = 0;
        int          expX;
        int          expY;
        int          expII;
        logic [24:0] doneII  = '0;
        col_t        doneCol = '0;
        row_t        doneRow = '0;
`ifdef II_SQUARED_EN
        logic [32:0] doneIISq = '0;
`endif

        fullReset      = 1'b1;
        fullFrameStart = 1'b0;
        fullReady      = 1'b0;
        fullY          = 8'd0;
        repeat (2) @(posedge clock);
        #1;
        fullReset = 1'b0;
        checkVal("full reset oOutput_ready", -1, 64'(fullOutReady), 64'd0);

        for (int c = 0; c < DEF_IMG_WIDTH * DEF_IMG_HEIGHT + 4; c++) begin
            fullFrameStart = (c == 0);
            fullReady      = (c < DEF_IMG_WIDTH * DEF_IMG_HEIGHT);
            fullY          = 8'd255;
            if (fullOutReady) begin
                expX  = outCount % DEF_IMG_WIDTH;
                expY  = outCount / DEF_IMG_WIDTH;
                expII = 255 * (expX + 1) * (expY + 1);
                if (fullII !== 25'(expII) || fullCol !== col_t'(expX) || fullRow !== row_t'(expY)) begin
                    sweepErr++;
                end
                outCount++;
            end
            if (fullDone) begin
                doneCount++;
                doneII  = fullII;
                doneCol = fullCol;
                doneRow = fullRow;
`ifdef II_SQUARED_EN
                doneIISq = fullIISq;
`endif
            end
            @(posedge clock);
            #1;
        end

        checkVal("full sweep mismatching beats", -1, 64'(sweepErr),  64'd0);
        checkVal("full output beat count",       -1, 64'(outCount),  64'd76800);
        checkVal("full oFrame_done pulses",      -1, 64'(doneCount), 64'd1);
        checkVal("full final oII",               -1, 64'(doneII),    64'd19584000);
        checkVal("full final oCol",              -1, 64'(doneCol),   64'd319);
        checkVal("full final oRow",              -1, 64'(doneRow),   64'd239);
`ifdef II_SQUARED_EN
        checkVal("full final oII_sq",            -1, 64'(doneIISq),  64'd4993920000);
`endif
    endtask

    initial begin
        $display("[TB] integral image bench, II width %0d, squared width %0d", DEF_II_W, DEF_II_SQ_W);
        fork
            runSmallTests();
            runFullFrame();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
